// File: rtl/dvi_timing_if.sv
// Raster timing bundle from the DVI timing generator to the pixel pipeline and TMDS encoders.
// All signals are produced in the clk_pix domain; there is no backpressure.
interface dvi_timing_if #(
    parameter int CORDW = 16
);
    logic signed [CORDW-1:0] sx;
    logic signed [CORDW-1:0] sy;
    logic                    frame;
    logic                    line;
    logic                    hsync;
    logic                    vsync;
    logic                    de;
    logic [1:0]              ctrl_ch0;
    logic [1:0]              ctrl_ch1;
    logic [1:0]              ctrl_ch2;

    modport master (
        output sx, sy, frame, line, hsync, vsync, de, ctrl_ch0, ctrl_ch1, ctrl_ch2
    );

    modport slave (
        input sx, sy, frame, line, hsync, vsync, de, ctrl_ch0, ctrl_ch1, ctrl_ch2
    );
endinterface

// File: rtl/dvi_timing_gen.sv
// DVI raster timing: signed sx/sy counters with line/frame pulses, plus sync/de/ctrl
// delayed PIPE cycles so they line up with pixel colour derived from sx/sy.
module dvi_timing_gen #(
    parameter int CORDW  = 16,
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0,
    parameter int PIPE   = 2
) (
    input  logic         clk_pix,
    input  logic         rst_pix,
    dvi_timing_if.master tmg
);
    localparam int H_STA_I = -(H_FP + H_SYNC + H_BP);
    localparam int V_STA_I = -(V_FP + V_SYNC + V_BP);

    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(H_STA_I);
    localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] HS_BEG = CORDW'(H_STA_I + H_FP);
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(H_STA_I + H_FP + H_SYNC - 1);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(V_STA_I);
    localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_RES - 1);
    localparam logic signed [CORDW-1:0] VS_BEG = CORDW'(V_STA_I + V_FP);
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(V_STA_I + V_FP + V_SYNC - 1);
    localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);

    localparam logic H_ACT = 1'(H_POL);
    localparam logic V_ACT = 1'(V_POL);

    logic signed [CORDW-1:0] sx_q, sy_q, sx_nx, sy_nx;
    logic                    line_q, frame_q;
    logic                    hs0, vs0, de0;
    logic                    hs_o, vs_o, de_o;

    always_comb begin
        sx_nx = sx_q + ONE;
        sy_nx = sy_q;
        if (sx_q == H_END) begin
            sx_nx = H_STA;
            sy_nx = (sy_q == V_END) ? V_STA : sy_q + ONE;
        end
    end

    // line/frame come from the next coordinate so they coincide with the pixel they mark
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sx_q    <= H_STA;
            sy_q    <= V_STA;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            sx_q    <= sx_nx;
            sy_q    <= sy_nx;
            line_q  <= (sx_nx == H_STA);
            frame_q <= (sx_nx == H_STA) && (sy_nx == V_STA);
        end
    end

    always_comb begin
        hs0 = ((sx_q >= HS_BEG) && (sx_q <= HS_END)) ? H_ACT : ~H_ACT;
        vs0 = ((sy_q >= VS_BEG) && (sy_q <= VS_END)) ? V_ACT : ~V_ACT;
        de0 = !sx_q[CORDW-1] && !sy_q[CORDW-1];
    end

    generate
        if (PIPE == 0) begin : g_nodly
            assign hs_o = hs0;
            assign vs_o = vs0;
            assign de_o = de0;
        end else begin : g_dly
            logic [PIPE-1:0] hs_d, vs_d, de_d;

            // reset clears every stage so no stale de can leak out after release
            always_ff @(posedge clk_pix or posedge rst_pix) begin
                if (rst_pix) begin
                    hs_d <= {PIPE{~H_ACT}};
                    vs_d <= {PIPE{~V_ACT}};
                    de_d <= '0;
                end else begin
                    hs_d[0] <= hs0;
                    vs_d[0] <= vs0;
                    de_d[0] <= de0;
                    for (int i = 1; i < PIPE; i++) begin
                        hs_d[i] <= hs_d[i-1];
                        vs_d[i] <= vs_d[i-1];
                        de_d[i] <= de_d[i-1];
                    end
                end
            end

            assign hs_o = hs_d[PIPE-1];
            assign vs_o = vs_d[PIPE-1];
            assign de_o = de_d[PIPE-1];
        end
    endgenerate

    assign tmg.sx       = sx_q;
    assign tmg.sy       = sy_q;
    assign tmg.line     = line_q;
    assign tmg.frame    = frame_q;
    assign tmg.hsync    = hs_o;
    assign tmg.vsync    = vs_o;
    assign tmg.de       = de_o;
    assign tmg.ctrl_ch0 = {vs_o, hs_o};
    assign tmg.ctrl_ch1 = 2'b00;
    assign tmg.ctrl_ch2 = 2'b00;
endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen: default 640x480 timing plus two small rasters (PIPE=2, and
// inverted polarity with PIPE=1), checked cycle by cycle against a behavioural raster model.
module tb_dvi_timing_gen;
  localparam int C_HRES [3] = '{640, 8, 8};
  localparam int C_HFP  [3] = '{16, 2, 2};
  localparam int C_HSW  [3] = '{96, 3, 3};
  localparam int C_HBP  [3] = '{48, 2, 2};
  localparam int C_VRES [3] = '{480, 6, 6};
  localparam int C_VFP  [3] = '{10, 1, 1};
  localparam int C_VSW  [3] = '{2, 2, 2};
  localparam int C_VBP  [3] = '{33, 2, 2};
  localparam int C_HPOL [3] = '{0, 0, 1};
  localparam int C_VPOL [3] = '{0, 0, 1};
  localparam int C_PIPE [3] = '{0, 2, 1};

  // clock / reset
  logic clk_pix = 1'b0;
  logic rst_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  dvi_timing_if #(.CORDW(16)) if_def ();
  dvi_timing_if #(.CORDW(16)) if_p2 ();
  dvi_timing_if #(.CORDW(16)) if_pol ();

  dvi_timing_gen #(
    .CORDW(16), .H_RES(C_HRES[0]), .H_FP(C_HFP[0]), .H_SYNC(C_HSW[0]), .H_BP(C_HBP[0]),
    .V_RES(C_VRES[0]), .V_FP(C_VFP[0]), .V_SYNC(C_VSW[0]), .V_BP(C_VBP[0]),
    .H_POL(C_HPOL[0]), .V_POL(C_VPOL[0]), .PIPE(C_PIPE[0])
  ) u_def (.clk_pix(clk_pix), .rst_pix(rst_pix), .tmg(if_def));

  dvi_timing_gen #(
    .CORDW(16), .H_RES(C_HRES[1]), .H_FP(C_HFP[1]), .H_SYNC(C_HSW[1]), .H_BP(C_HBP[1]),
    .V_RES(C_VRES[1]), .V_FP(C_VFP[1]), .V_SYNC(C_VSW[1]), .V_BP(C_VBP[1]),
    .H_POL(C_HPOL[1]), .V_POL(C_VPOL[1]), .PIPE(C_PIPE[1])
  ) u_p2 (.clk_pix(clk_pix), .rst_pix(rst_pix), .tmg(if_p2));

  dvi_timing_gen #(
    .CORDW(16), .H_RES(C_HRES[2]), .H_FP(C_HFP[2]), .H_SYNC(C_HSW[2]), .H_BP(C_HBP[2]),
    .V_RES(C_VRES[2]), .V_FP(C_VFP[2]), .V_SYNC(C_VSW[2]), .V_BP(C_VBP[2]),
    .H_POL(C_HPOL[2]), .V_POL(C_VPOL[2]), .PIPE(C_PIPE[2])
  ) u_pol (.clk_pix(clk_pix), .rst_pix(rst_pix), .tmg(if_pol));

  // observed outputs, packed {ctrl_ch2, ctrl_ch1, ctrl_ch0, hsync, vsync, de, line, frame}
  int         o_sx [3];
  int         o_sy [3];
  logic [10:0] o_vec [3];
  always_comb begin
    o_sx[0] = int'(if_def.sx);
    o_sy[0] = int'(if_def.sy);
    o_sx[1] = int'(if_p2.sx);
    o_sy[1] = int'(if_p2.sy);
    o_sx[2] = int'(if_pol.sx);
    o_sy[2] = int'(if_pol.sy);
    o_vec[0] = {if_def.ctrl_ch2, if_def.ctrl_ch1, if_def.ctrl_ch0, if_def.hsync,
                if_def.vsync, if_def.de, if_def.line, if_def.frame};
    o_vec[1] = {if_p2.ctrl_ch2, if_p2.ctrl_ch1, if_p2.ctrl_ch0, if_p2.hsync,
                if_p2.vsync, if_p2.de, if_p2.line, if_p2.frame};
    o_vec[2] = {if_pol.ctrl_ch2, if_pol.ctrl_ch1, if_pol.ctrl_ch0, if_pol.hsync,
                if_pol.vsync, if_pol.de, if_pol.line, if_pol.frame};
  end

  int n_tests = 0;
  int n_fail  = 0;
  string nm [3] = '{"def", "p2", "pol"};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural raster model
  int m_sx [3];
  int m_sy [3];

  function automatic int hsta(input int k);
    return -(C_HFP[k] + C_HSW[k] + C_HBP[k]);
  endfunction

  function automatic int vsta(input int k);
    return -(C_VFP[k] + C_VSW[k] + C_VBP[k]);
  endfunction

  function automatic logic [2:0] terms(input int k, input int x, input int y);
    int  hb, vb;
    logic hs_in, vs_in, hs, vs, de;
    hb    = hsta(k) + C_HFP[k];
    vb    = vsta(k) + C_VFP[k];
    hs_in = (x >= hb) && (x < hb + C_HSW[k]);
    vs_in = (y >= vb) && (y < vb + C_VSW[k]);
    hs    = hs_in ? (C_HPOL[k] != 0) : (C_HPOL[k] == 0);
    vs    = vs_in ? (C_VPOL[k] != 0) : (C_VPOL[k] == 0);
    de    = (x >= 0) && (y >= 0);
    return {hs, vs, de};
  endfunction

  task automatic advance(input int k);
    if (m_sx[k] == C_HRES[k] - 1) begin
      m_sx[k] = hsta(k);
      if (m_sy[k] == C_VRES[k] - 1) m_sy[k] = vsta(k);
      else m_sy[k] = m_sy[k] + 1;
    end else begin
      m_sx[k] = m_sx[k] + 1;
    end
  endtask

  // scoreboard: {hs, vs, de} pushed when a coordinate is produced, popped PIPE cycles later
  logic [2:0] exp_q0 [$];
  logic [2:0] exp_q1 [$];
  logic [2:0] exp_q2 [$];

  task automatic sb_reset(input int k);
    logic [2:0] r;
    r = {(C_HPOL[k] == 0), (C_VPOL[k] == 0), 1'b0};
    case (k)
      0: begin exp_q0.delete(); repeat (C_PIPE[k]) exp_q0.push_back(r); end
      1: begin exp_q1.delete(); repeat (C_PIPE[k]) exp_q1.push_back(r); end
      default: begin exp_q2.delete(); repeat (C_PIPE[k]) exp_q2.push_back(r); end
    endcase
  endtask

  task automatic sb_step(input int k, input logic [2:0] now, output logic [2:0] dly);
    case (k)
      0: begin exp_q0.push_back(now); dly = exp_q0.pop_front(); end
      1: begin exp_q1.push_back(now); dly = exp_q1.pop_front(); end
      default: begin exp_q2.push_back(now); dly = exp_q2.pop_front(); end
    endcase
  endtask

  // run-length trackers
  int   cyc = 0;
  int   def_last_line, def_hs_len, def_vs_len, def_de_len;
  logic def_hs_prev, def_vs_prev, def_de_prev;
  int   p2_last_frame, p2_de_cnt, p2_early;
  logic p2_fr_valid, p2_seen_act;
  int   pol_hs_len, pol_vs_len;
  logic pol_hs_prev, pol_vs_prev;

  always @(negedge clk_pix) begin
    logic [2:0] now, dly;
    logic       ln, fr;
    if (rst_pix) begin
      for (int k = 0; k < 3; k++) begin
        m_sx[k] = hsta(k);
        m_sy[k] = vsta(k);
        sb_reset(k);
      end
      def_last_line = -1; def_hs_len = 0; def_vs_len = 0; def_de_len = 0;
      def_hs_prev = 1'b1; def_vs_prev = 1'b1; def_de_prev = 1'b0;
      p2_last_frame = -1; p2_de_cnt = 0; p2_fr_valid = 1'b0; p2_seen_act = 1'b0;
      pol_hs_len = 0; pol_vs_len = 0; pol_hs_prev = 1'b0; pol_vs_prev = 1'b0;
    end else begin
      cyc++;
      for (int k = 0; k < 3; k++) begin
        advance(k);
        now = terms(k, m_sx[k], m_sy[k]);
        sb_step(k, now, dly);
        ln = (m_sx[k] == hsta(k));
        fr = ln && (m_sy[k] == vsta(k));
        check({nm[k], "_sxsy"}, {o_sx[k], o_sy[k]}, {m_sx[k], m_sy[k]});
        check({nm[k], "_outs"}, 64'(o_vec[k]),
              64'({4'b0000, dly[1], dly[2], dly[2], dly[1], dly[0], ln, fr}));
      end

      // default raster: line period, hsync/vsync pulse placement and width, de run width
      if (if_def.line) begin
        if (def_last_line >= 0) check("def_line_period", 64'(cyc - def_last_line), 64'(800));
        def_last_line = cyc;
      end
      if (!if_def.hsync && def_hs_prev) begin
        check("def_hs_start_sx", 64'(o_sx[0]), 64'(-144));
        def_hs_len = 0;
      end
      if (!if_def.hsync) def_hs_len++;
      if (if_def.hsync && !def_hs_prev) check("def_hs_len", 64'(def_hs_len), 64'(96));
      def_hs_prev = if_def.hsync;
      if (!if_def.vsync && def_vs_prev) begin
        check("def_vs_start", {o_sx[0], o_sy[0]}, {32'(-160), 32'(-35)});
        def_vs_len = 0;
      end
      if (!if_def.vsync) def_vs_len++;
      if (if_def.vsync && !def_vs_prev) check("def_vs_len", 64'(def_vs_len), 64'(1600));
      def_vs_prev = if_def.vsync;
      if (if_def.de && !def_de_prev) begin
        check("def_de_row", 64'(o_sy[0] >= 0), 64'(1));
        def_de_len = 0;
      end
      if (if_def.de) def_de_len++;
      if (!if_def.de && def_de_prev) check("def_de_len", 64'(def_de_len), 64'(640));
      def_de_prev = if_def.de;

      // small raster, PIPE=2: frame period, de cycles per frame, no de before first active row
      if (o_sy[1] >= 0) p2_seen_act = 1'b1;
      if (!p2_seen_act && if_p2.de) p2_early++;
      if (if_p2.de) p2_de_cnt++;
      if (if_p2.frame) begin
        if (p2_fr_valid) begin
          check("p2_frame_period", 64'(cyc - p2_last_frame), 64'(165));
          check("p2_de_per_frame", 64'(p2_de_cnt), 64'(48));
        end
        p2_fr_valid = 1'b1;
        p2_last_frame = cyc;
        p2_de_cnt = 0;
      end

      // active-high syncs
      if (if_pol.hsync) pol_hs_len++;
      if (!if_pol.hsync && pol_hs_prev) begin
        check("pol_hs_len", 64'(pol_hs_len), 64'(3));
        pol_hs_len = 0;
      end
      pol_hs_prev = if_pol.hsync;
      if (if_pol.vsync) pol_vs_len++;
      if (!if_pol.vsync && pol_vs_prev) begin
        check("pol_vs_len", 64'(pol_vs_len), 64'(30));
        pol_vs_len = 0;
      end
      pol_vs_prev = if_pol.vsync;
    end
  end

  initial begin
    logic found;
    p2_early = 0;

    // asynchronous reset before any clock edge
    #2 rst_pix = 1'b1;
    #1;
    check("rst_def_sxsy", {o_sx[0], o_sy[0]}, {32'(-160), 32'(-45)});
    check("rst_def_outs", 64'(o_vec[0]), 64'(11'b0000_11_110_00));
    check("rst_p2_sxsy", {o_sx[1], o_sy[1]}, {32'(-7), 32'(-5)});
    check("rst_p2_outs", 64'(o_vec[1]), 64'(11'b0000_11_110_00));
    check("rst_pol_outs", 64'(o_vec[2]), 64'(11'b0000_00_000_00));
    repeat (3) @(negedge clk_pix);
    check("rst_hold_def_sx", 64'(o_sx[0]), 64'(-160));
    #1 rst_pix = 1'b0;

    // long run: default raster into its first active line, many small frames
    repeat (37000) @(negedge clk_pix);

    // mid-frame reset on the PIPE=2 raster while de is high
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_pix);
      if (o_sx[1] == 2 && o_sy[1] == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("p2_mid_found", 64'(found), 64'(1));
    check("p2_de_before_rst", 64'(if_p2.de), 64'(1));
    #2 rst_pix = 1'b1;
    #1;
    check("p2_mid_rst_sxsy", {o_sx[1], o_sy[1]}, {32'(-7), 32'(-5)});
    check("p2_mid_rst_outs", 64'(o_vec[1]), 64'(11'b0000_11_110_00));
    check("def_mid_rst_outs", 64'(o_vec[0]), 64'(11'b0000_11_110_00));
    repeat (2) @(negedge clk_pix);
    #1 rst_pix = 1'b0;
    repeat (400) @(negedge clk_pix);
    check("p2_de_before_active", 64'(p2_early), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dvi_timing_gen.md
Name: dvi_timing_gen

Overview:
- Generates the raster timing that drives the three TMDS encoder lanes of the DVI output path: `de` for all lanes, per-lane 2-bit control words, and signed screen coordinates for the pixel pipeline.
- Sync, `de` and control outputs are delayed by a configurable number of cycles. This keeps them aligned with pixel colour that takes PIPE cycles to produce from `sx`/`sy`.
- Sits directly upstream of the encoders in the `clk_pix` domain.

Parameters:
CORDW, 16, coordinate width (signed)
H_RES, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_RES, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
PIPE, 2, delay in cycles of hsync/vsync/de/ctrl relative to sx/sy (0..15)

Ports:
clk_pix  in  1  pixel clock
rst_pix  in  1  reset
sx  out  CORDW  signed horizontal coordinate
sy  out  CORDW  signed vertical coordinate
frame  out  1  pulse, first pixel of frame (aligned with sx/sy)
line  out  1  pulse, first pixel of each line (aligned with sx/sy)
hsync  out  1  horizontal sync, delayed PIPE
vsync  out  1  vertical sync, delayed PIPE
de  out  1  data enable, delayed PIPE
ctrl_ch0  out  2  {vsync, hsync} for blue lane encoder, delayed PIPE
ctrl_ch1  out  2  green lane control, constant 2'b00
ctrl_ch2  out  2  red lane control, constant 2'b00

Behaviour:
- One clock, `clk_pix`. Reset `rst_pix` is asynchronous and active-high.
- Constants:
  - H_STA = -(H_FP+H_SYNC+H_BP); V_STA = -(V_FP+V_SYNC+V_BP).
  - Defaults give H_STA = -160 and V_STA = -45, so a line is 800 cycles and a frame is 525 lines.
- Coordinates:
  - `sx` counts H_STA..H_RES-1, then wraps to H_STA.
  - At the wrap, `sy` increments; after V_RES-1 it wraps to V_STA.
  - Both are registered and change only on the `clk_pix` edge.
- Horizontal regions (default values):
  - front porch: sx in [H_STA, H_STA+H_FP-1] = [-160,-145]
  - sync: [H_STA+H_FP, H_STA+H_FP+H_SYNC-1] = [-144,-49]
  - back porch: [-48,-1]
  - active: [0, H_RES-1]
- Vertical regions are the same form using V_* parameters: sync is sy in [-35,-34], active is sy >= 0.
- Undelayed terms (same cycle as sx/sy):
  - hs0 = H_POL when sx in the sync region, else ~H_POL. vs0 likewise from sy, using V_POL.
  - de0 = (sx >= 0) && (sy >= 0).
  - `line` = (sx == H_STA).
  - `frame` = (sx == H_STA) && (sy == V_STA).
  - `line` and `frame` are registered alongside sx/sy (computed from the next coordinate), so they are true in exactly the cycle sx/sy show that pixel. They are never delayed.
- Delay line:
  - hs0, vs0 and de0 pass through a PIPE-stage shift register; PIPE=0 means outputs equal hs0/vs0/de0 in the same cycle.
  - `ctrl_ch0` = {vsync, hsync} taken from the delayed values. `ctrl_ch1` and `ctrl_ch2` are tied to 2'b00.
- Reset values (asynchronous, immediate):
  - sx=H_STA, sy=V_STA; frame=0, line=0.
  - All delay stages: hs=~H_POL, vs=~V_POL, de=0.
  - With defaults: hsync=1, vsync=1, de=0, ctrl_ch0=2'b11.
- First clock after reset release: sx=H_STA+1, frame=0. The next frame pulse occurs when the counters wrap to (H_STA, V_STA).
- Reset mid-frame: counters and every delay stage return to reset values at once. No partial de pulse may appear after release, because the delay stages hold de=0.
- Widths: comparisons are signed. CORDW must hold H_STA..H_RES-1 and V_STA..V_RES-1; with the defaults, 11 bits would suffice.

Test Plan:
- Reset, defaults: hold rst_pix high -> sx=-160, sy=-45, hsync=1, vsync=1, de=0, ctrl_ch0=2'b11, frame=0, line=0. Assert rst_pix asynchronously between clock edges -> outputs change immediately.
- Line timing, PIPE=0: count cycles over one line -> 800 cycles between `line` pulses; hsync low for exactly 96 cycles, starting when sx=-144; de high for 640 cycles only when sy >= 0.
- Frame timing: run 2 full frames -> `frame` pulses 420000 cycles apart; vsync low for 1600 cycles (2 lines) starting at sx=-160, sy=-35; 307200 de-high cycles per frame.
- PIPE alignment: PIPE=2 vs PIPE=0 reference -> hsync/vsync/de/ctrl_ch0 identical but 2 cycles later; sx/sy/frame/line unchanged.
- Polarity: H_POL=1, V_POL=1 -> sync pulses high; reset value ctrl_ch0=2'b00. ctrl_ch1 and ctrl_ch2 are 2'b00 throughout all runs.
- Mid-frame reset: assert rst_pix at sx=100, sy=200 with de high -> de drops immediately; after release, de stays 0 until sy reaches 0 in the next frame (PIPE=2 included).
